det_stream_sched: RTL
=====================

DET_STREAM_SCHED -- requirements
Module: det_stream_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter WORD_W, default 8, bits per request word (4..32).
REQ-003 Parameter CNT_W, default $clog2(WORD_W+1), width of the match-count result.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-high.
REQ-006 req  input  NREQ  per-requester request level; held until the matching gnt bit.
REQ-007 word  input  NREQ*WORD_W  per-requester data word; slice i = word[i*WORD_W +: WORD_W].
REQ-008 gnt  output  NREQ  one-hot, one-cycle grant pulse; word latched on this cycle.
REQ-009 ser_bit  output  1  bit currently presented to the detector.
REQ-010 busy  output  1  high in SHIFT and REPORT.
REQ-011 done  output  1  one-cycle result-valid pulse.
REQ-012 done_id  output  $clog2(NREQ)  index of the requester whose result is on match_cnt.
REQ-013 match_cnt  output  CNT_W  number of "1011" matches found in the word; valid when done=1.

Function
REQ-014 FSM states: IDLE, SHIFT, REPORT.
REQ-015 IDLE: if any req bit is high, pick a winner round-robin, pulse its gnt, latch its word and index, clear the bit counter and detector, then go to SHIFT; otherwise stay in IDLE with gnt=0.
REQ-016 Round-robin: search starts at the index after the last winner, wrapping at NREQ-1 to 0; after reset, index 0 has highest priority.
REQ-017 SHIFT: present latched word MSB first, one bit per cycle, for exactly WORD_W cycles on ser_bit; then go to REPORT.
REQ-018 Detector is Mealy: match=1 in the cycle where the state is S101 and ser_bit=1; match_cnt increments in that same cycle, including on the last bit.
REQ-019 Detector states: IDLE, S1, S10, S101.
- IDLE: 1->S1, 0->IDLE.
- S1: 1->S1, 0->S10.
- S10: 1->S101, 0->IDLE.
- S101: 1->match (see REQ-030), 0->S10.
REQ-020 REPORT: done=1 for exactly one cycle with done_id and final match_cnt; then go to IDLE.
REQ-021 match_cnt and done_id hold their values after REPORT until the next grant clears match_cnt.
REQ-022 Throughput: WORD_W+2 cycles per word (grant, WORD_W shift cycles, report); no new grant while busy.
REQ-023 req changes during SHIFT/REPORT have no effect on the word in flight.
REQ-024 match_cnt saturates at 2**CNT_W-1; this is unreachable with the default CNT_W.

Reset
REQ-025 rst=1 asynchronously forces: FSM and detector to IDLE, gnt=0, done=0, busy=0, ser_bit=0, match_cnt=0, done_id=0, bit counter=0, round-robin pointer so that index 0 has top priority.
REQ-026 Reset during SHIFT or REPORT aborts the word: no done pulse, and the requester is not re-granted automatically.
REQ-027 After rst deasserts, the first grant can occur on the first rising edge.

Configuration
REQ-028 Macro DET_OVERLAP_EN selects the detector behaviour after a match.
REQ-029 With DET_OVERLAP_EN defined: on a match, the detector goes to S1, so overlapping patterns count.
REQ-030 Without DET_OVERLAP_EN: on a match, the detector goes to IDLE (non-overlapping count).

Structure
REQ-031 Shared package det_pkg holds:
- the FSM state enum (IDLE, SHIFT, REPORT);
- the detector state enum (IDLE, S1, S10, S101);
- the pattern constant 4'b1011.
REQ-032 The detector is a separate sub-module, det_1011_mealy, with ports clk, rst, clr, in, match.
REQ-033 The round-robin arbiter stays inline in det_stream_sched.

Verification
REQ-034 Reset, then req=4'b0001, word0=8'hBB -> gnt=0001 one cycle; done 9 cycles later; match_cnt=2; done_id=0.
REQ-035 req0 with word0=8'hB6:
- with DET_OVERLAP_EN -> match_cnt=2;
- without DET_OVERLAP_EN -> match_cnt=1.
REQ-036 req=4'b1111 held, re-raised after each grant -> grant order 0,1,2,3,0; each done exactly 10 cycles apart.
REQ-037 req2 with word2=8'h0B -> match_cnt=1 (match on the last bit), done_id=2.
REQ-038 rst pulsed at SHIFT cycle 4 of a 4'b0100 grant -> no done; all outputs 0; a later req=4'b0110 is granted index 1 first.
REQ-039 req0 with word0=8'h00 and 8'hFF -> match_cnt=0 for both; busy high exactly 9 cycles per word.

Source files
------------

// File: rtl/det_pkg.sv
// Shared types and constants for the serial "1011" detector stream scheduler.
// Optional feature macro: DET_OVERLAP_EN (overlapping match counting in det_1011_mealy).
package det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } fsm_state_e;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_S1   = 2'd1,
        D_S10  = 2'd2,
        D_S101 = 2'd3
    } det_state_e;

    localparam logic [3:0] DET_PATTERN = 4'b1011;

endpackage

// File: rtl/det_stream_sched_if.sv
// Requester/result bus of det_stream_sched; slave = scheduler, master = requester side.
interface det_stream_sched_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
);
    localparam int unsigned ID_W = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] word;
    logic [NREQ-1:0]        gnt;
    logic                   ser_bit;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [CNT_W-1:0]       match_cnt;

    modport master (
        output req, word,
        input  gnt, ser_bit, busy, done, done_id, match_cnt
    );

    modport slave (
        input  req, word,
        output gnt, ser_bit, busy, done, done_id, match_cnt
    );

endinterface

// File: rtl/det_1011_mealy.sv
// Mealy "1011" detector; match is combinational in the cycle the final bit is presented.
// Macro DET_OVERLAP_EN: after a match resume from S1 (overlapping) instead of IDLE.
module det_1011_mealy
    import det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in,
    output logic match
);

    det_state_e state_q;

    assign match = (state_q == D_S101) && (in == DET_PATTERN[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= D_IDLE;
        end else if (clr) begin
            state_q <= D_IDLE;
        end else begin
            case (state_q)
                D_IDLE: state_q <= (in == DET_PATTERN[3]) ? D_S1 : D_IDLE;
                D_S1:   state_q <= (in == DET_PATTERN[2]) ? D_S10 : D_S1;
                D_S10:  state_q <= (in == DET_PATTERN[1]) ? D_S101 : D_IDLE;
                D_S101: begin
                    if (match) begin
`ifdef DET_OVERLAP_EN
                        state_q <= D_S1;
`else
                        state_q <= D_IDLE;
`endif
                    end else begin
                        state_q <= D_S10;
                    end
                end
                default: state_q <= D_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/det_stream_sched.sv
// Round-robin scheduler that serialises one requester word at a time into the 1011 detector.
// Macro DET_OVERLAP_EN (consumed by det_1011_mealy) selects overlapping match counting.
module det_stream_sched
    import det_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    det_stream_sched_if.slave bus
);

    localparam int unsigned ID_W = $clog2(NREQ);
    localparam int unsigned BC_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fsm_state_e         state_q;
    logic [NREQ-1:0]    gnt_q;
    logic [WORD_W-1:0]  word_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    ptr_q;
    logic [BC_W-1:0]    bitcnt_q;
    logic               ser_bit_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [ID_W-1:0]    win_d;
    logic               win_vld_d;
    int unsigned        rr_idx;
    logic [ID_W-1:0]    rr_idx_c;
    logic               match_c;
    logic               det_clr_c;
    logic               cnt_en_c;

    // Round-robin search starting at ptr_q, wrapping at NREQ-1.
    always_comb begin
        win_d     = ptr_q;
        win_vld_d = 1'b0;
        rr_idx    = 0;
        rr_idx_c  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rr_idx = 32'(ptr_q) + i;
            if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
            rr_idx_c = ID_W'(rr_idx);
            if (!win_vld_d && bus.req[rr_idx_c]) begin
                win_vld_d = 1'b1;
                win_d     = rr_idx_c;
            end
        end
    end

    assign det_clr_c = (state_q == ST_IDLE) && win_vld_d;
    // Bits are on ser_bit from the cycle after the grant pulse up to the cycle before done.
    assign cnt_en_c  = busy_q && !done_q;

    det_1011_mealy u_det (
        .clk   (clk),
        .rst   (rst),
        .clr   (det_clr_c),
        .in    (ser_bit_q),
        .match (match_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            word_q    <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            bitcnt_q  <= '0;
            ser_bit_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q    <= 1'b0;
                    ser_bit_q <= 1'b0;
                    if (win_vld_d) begin
                        gnt_q    <= NREQ'(1) << win_d;
                        word_q   <= bus.word[32'(win_d)*WORD_W +: WORD_W];
                        id_q     <= win_d;
                        ptr_q    <= (32'(win_d) == NREQ - 1) ? '0 : win_d + 1'b1;
                        bitcnt_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    busy_q    <= 1'b1;
                    ser_bit_q <= word_q[WORD_W-1];
                    word_q    <= {word_q[WORD_W-2:0], 1'b0};
                    bitcnt_q  <= bitcnt_q + 1'b1;
                    if (bitcnt_q == BC_W'(WORD_W - 1)) state_q <= ST_REPORT;
                end
                ST_REPORT: begin
                    done_q    <= 1'b1;
                    ser_bit_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (cnt_en_c && match_c && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ser_bit   = ser_bit_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = id_q;
    assign bus.match_cnt = cnt_q;

endmodule
